node_integrator: RTL and testbench

//  Downstream of the ideal-shape spring stage. Collects the per-node spring forces it streams out
//  (one force_valid pulse per node, node order 0..NUM_NODES-1). Applies a semi-implicit Euler step
//  to every node's velocity and position. Presents the new state arrays for the next physics frame.

---
 rtl/node_integrator.sv | 114 +++++++++++
 tb/tb_node_integrator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/node_integrator.sv
// node_integrator: collects streamed per-node spring forces and applies a semi-implicit Euler step
module node_integrator #(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int DT_SHIFT      = 2
) (
    input  logic                                          clk_in,
    input  logic                                          rst_in,
    input  logic                                          start_in,
    input  logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_in,
    input  logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_in,
    input  logic [FORCE_SIZE-1:0]                         force_x_in,
    input  logic [FORCE_SIZE-1:0]                         force_y_in,
    input  logic                                          force_valid_in,
    input  logic                                          forces_done_in,
    output logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]  nodes_out,
    output logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0]  velocities_out,
    output logic                                          busy_out,
    output logic                                          output_valid,
    output logic                                          overrun_out
);
    localparam int IW = $clog2(NUM_NODES + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_NODES - 1);
    localparam logic [IW-1:0] FULL = IW'(NUM_NODES);
    localparam int VMAX = 2 ** (VELOCITY_SIZE - 1) - 1;
    localparam int PMAX = 2 ** (POSITION_SIZE - 1) - 1;
    typedef enum logic [1:0] {IDLE, COLLECT, UPDATE, DONE} state_t;
    state_t state, state_d;
    logic [IW-1:0] idx;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0] pos_q;
    logic [1:0][NUM_NODES-1:0][VELOCITY_SIZE-1:0] vel_q;
    logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]    frc_q;
    logic [1:0][VELOCITY_SIZE-1:0] v_new;
    logic [1:0][POSITION_SIZE-1:0] p_new;

    // Sums are formed at 32 bits so they can never wrap before clamping
    function automatic logic [VELOCITY_SIZE-1:0] sat_vel(input logic signed [31:0] s);
        return s > VMAX ? VELOCITY_SIZE'(VMAX) : s < -VMAX - 1 ? VELOCITY_SIZE'(-VMAX - 1) : s[VELOCITY_SIZE-1:0];
    endfunction

    function automatic logic [POSITION_SIZE-1:0] sat_pos(input logic signed [31:0] s);
        return s > PMAX ? POSITION_SIZE'(PMAX) : s < -PMAX - 1 ? POSITION_SIZE'(-PMAX - 1) : s[POSITION_SIZE-1:0];
    endfunction

    // Integrate node idx on both axes; the position step uses the freshly updated velocity
    always_comb begin
        for (int a = 0; a < 2; a++) begin
            v_new[a] = sat_vel(32'($signed(vel_q[a][idx])) + 32'($signed(frc_q[a][idx]) >>> DT_SHIFT));
            p_new[a] = sat_pos(32'($signed(pos_q[a][idx])) + 32'($signed(v_new[a]) >>> DT_SHIFT));
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_d      = state;
        busy_out     = state != IDLE;
        output_valid = state == DONE;
        case (state)
            IDLE:    state_d = start_in ? COLLECT : IDLE;
            COLLECT: state_d = forces_done_in ? UPDATE : COLLECT;
            UPDATE:  state_d = idx == LAST ? DONE : UPDATE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_d;
    end

    // Frame latch, force collection and per-node write-back
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx            <= '0;
            pos_q          <= '0;
            vel_q          <= '0;
            frc_q          <= '0;
            nodes_out      <= '0;
            velocities_out <= '0;
            overrun_out    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_in) begin
                    pos_q <= nodes_in;
                    vel_q <= velocities_in;
                    frc_q <= '0;
                    idx   <= '0;
                end
                COLLECT: begin
                    if (force_valid_in) begin
                        if (idx == FULL) overrun_out <= 1'b1;
                        else begin
                            frc_q[0][idx] <= force_x_in;
                            frc_q[1][idx] <= force_y_in;
                            idx           <= idx + 1'b1;
                        end
                    end
                    if (forces_done_in) idx <= '0;
                end
                UPDATE: begin
                    for (int a = 0; a < 2; a++) begin
                        velocities_out[a][idx] <= v_new[a];
                        nodes_out[a][idx]      <= p_new[a];
                    end
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_node_integrator.sv
// tb_node_integrator: randomized frames checked every cycle against a frame-level integrator model
module tb_node_integrator;
    localparam int N = 10, PW = 8, VW = 8, FW = 8, DT = 2;

    logic clk_in = 0, rst_in = 1, start_in = 0, force_valid_in = 0, forces_done_in = 0;
    logic [1:0][N-1:0][PW-1:0] nodes_in = '0, nodes_out, ep;
    logic [1:0][N-1:0][VW-1:0] velocities_in = '0, velocities_out, ev;
    logic [FW-1:0] force_x_in = '0, force_y_in = '0;
    logic busy_out, output_valid, overrun_out;
    int total = 0, bad = 0, lat;
    bit chk_en = 0;

    int m_p[2][N], m_v[2][N], m_f[2][N], m_np[2][N], m_nv[2][N], m_cp[2][N], m_cv[2][N];
    bit m_active, m_coll, m_valid, m_ovr;
    int m_cd, m_n;

    node_integrator dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .nodes_in(nodes_in), .velocities_in(velocities_in),
        .force_x_in(force_x_in), .force_y_in(force_y_in),
        .force_valid_in(force_valid_in), .forces_done_in(forces_done_in),
        .nodes_out(nodes_out), .velocities_out(velocities_out),
        .busy_out(busy_out), .output_valid(output_valid), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic int sat(input int x, input int w);
        int hi = (1 << (w - 1)) - 1;
        return x > hi ? hi : x < -hi - 1 ? -hi - 1 : x;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Frame-level model: a frame latches its inputs, gathers up to N forces, then reveals one new node per cycle
    initial forever begin
        @(posedge clk_in);
        if (rst_in) begin
            m_active = 0; m_coll = 0; m_valid = 0; m_ovr = 0; m_cd = 0; m_n = 0;
            for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) begin m_cp[a][i] = 0; m_cv[a][i] = 0; end
        end else if (m_valid) begin
            m_valid = 0; m_active = 0;
        end else if (!m_active) begin
            if (start_in) begin
                m_active = 1; m_coll = 1; m_n = 0;
                for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) begin
                    m_p[a][i] = int'($signed(nodes_in[a][i]));
                    m_v[a][i] = int'($signed(velocities_in[a][i]));
                    m_f[a][i] = 0;
                end
            end
        end else if (m_coll) begin
            if (force_valid_in) begin
                if (m_n < N) begin
                    m_f[0][m_n] = int'($signed(force_x_in));
                    m_f[1][m_n] = int'($signed(force_y_in));
                    m_n++;
                end else m_ovr = 1;
            end
            if (forces_done_in) begin
                m_coll = 0; m_cd = N;
                for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) begin
                    m_nv[a][i] = sat(m_v[a][i] + (m_f[a][i] >>> DT), VW);
                    m_np[a][i] = sat(m_p[a][i] + (m_nv[a][i] >>> DT), PW);
                end
            end
        end else begin
            m_cd--;
            if (m_cd == 0) begin m_valid = 1; m_cp = m_np; m_cv = m_nv; end
        end
    end

    // Compare every output against the model on every cycle
    initial forever begin
        @(negedge clk_in);
        if (chk_en) begin
            for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) begin
                ep[a][i] = PW'((m_active && !m_coll && !m_valid && i < N - m_cd) ? m_np[a][i] : m_cp[a][i]);
                ev[a][i] = VW'((m_active && !m_coll && !m_valid && i < N - m_cd) ? m_nv[a][i] : m_cv[a][i]);
            end
            check("output_valid", 256'(output_valid), 256'(m_valid));
            check("busy", 256'(busy_out), 256'(m_active));
            check("overrun", 256'(overrun_out), 256'(m_ovr));
            check("nodes", 256'(nodes_out), 256'(ep));
            check("velocities", 256'(velocities_out), 256'(ev));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fill(input int px, input int py, input int vx, input int vy);
        for (int i = 0; i < N; i++) begin
            nodes_in[0][i] = PW'(px); nodes_in[1][i] = PW'(py);
            velocities_in[0][i] = VW'(vx); velocities_in[1][i] = VW'(vy);
        end
    endtask

    task automatic start_frame();
        start_in = 1;
        tick();
        start_in = 0;
    endtask

    task automatic send_force(input int fx, input int fy);
        force_x_in = FW'(fx); force_y_in = FW'(fy); force_valid_in = 1;
        tick();
        force_valid_in = 0;
    endtask

    task automatic finish(input bit with_f, input int fx, input int fy, output int l);
        force_x_in = FW'(fx); force_y_in = FW'(fy); force_valid_in = with_f; forces_done_in = 1;
        tick();
        force_valid_in = 0; forces_done_in = 0;
        l = 1;
        while (!output_valid && l < 40) begin tick(); l++; end
        check("latency", 256'(l), 256'(N + 1));
    endtask

    task automatic rand_frame();
        int nf;
        force_valid_in = 1; forces_done_in = 1'($urandom_range(0, 1));
        tick();
        force_valid_in = 0; forces_done_in = 0;
        for (int a = 0; a < 2; a++) for (int i = 0; i < N; i++) begin
            nodes_in[a][i] = PW'($urandom); velocities_in[a][i] = VW'($urandom);
        end
        start_frame();
        nf = $urandom_range(0, 12);
        for (int k = 0; k < nf; k++) begin
            repeat ($urandom_range(0, 2)) begin
                start_in = ($urandom_range(0, 2) == 0);
                tick();
                start_in = 0;
            end
            send_force(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
        end
        finish(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), lat);
        tick();
    endtask

    initial begin
        tick(); tick();
        rst_in = 0; chk_en = 1;
        // zero forces and velocities leave positions untouched
        fill(5, -3, 0, 0); start_frame();
        finish(0, 0, 0, lat);
        check("t1 p0x", 256'(nodes_out[0][0]), 256'(8'd5));
        check("t1 p9y", 256'(nodes_out[1][9]), 256'(8'hFD));
        tick();
        // single node force
        fill(0, 0, 0, 0); start_frame();
        repeat (3) send_force(0, 0);
        send_force(8, -8);
        repeat (6) send_force(0, 0);
        finish(0, 0, 0, lat);
        check("t2 v3x", 256'(velocities_out[0][3]), 256'(8'd2));
        check("t2 v3y", 256'(velocities_out[1][3]), 256'(8'hFE));
        check("t2 p3x", 256'(nodes_out[0][3]), 256'(8'd0));
        check("t2 p3y", 256'(nodes_out[1][3]), 256'(8'hFF));
        tick();
        // saturation of both velocity and position
        fill(125, -127, 126, -127); start_frame();
        send_force(127, -128);
        finish(0, 0, 0, lat);
        check("t3 v0x", 256'(velocities_out[0][0]), 256'(8'd127));
        check("t3 v0y", 256'(velocities_out[1][0]), 256'(8'h80));
        check("t3 p0x", 256'(nodes_out[0][0]), 256'(8'd127));
        check("t3 p0y", 256'(nodes_out[1][0]), 256'(8'h80));
        tick();
        // early done with the last force in the same cycle
        fill(0, 0, 0, 0); start_frame();
        repeat (3) send_force(4, 4);
        finish(1, 12, -12, lat);
        check("t5 v2x", 256'(velocities_out[0][2]), 256'(8'd1));
        check("t5 v3x", 256'(velocities_out[0][3]), 256'(8'd3));
        check("t5 v3y", 256'(velocities_out[1][3]), 256'(8'hFD));
        check("t5 p3y", 256'(nodes_out[1][3]), 256'(8'hFF));
        check("t5 v4x", 256'(velocities_out[0][4]), 256'(8'd0));
        tick();
        // twelve forces: two dropped, overrun sticks
        fill(0, 0, 0, 0); start_frame();
        for (int k = 0; k < 12; k++) send_force(k + 1, -(k + 1));
        finish(0, 0, 0, lat);
        check("t4 overrun", 256'(overrun_out), 256'(1'b1));
        check("t4 v9x", 256'(velocities_out[0][9]), 256'(8'd2));
        check("t4 v9y", 256'(velocities_out[1][9]), 256'(8'hFD));
        tick();
        repeat (20) rand_frame();
        // reset in the middle of the update sweep
        fill(7, 7, 20, -20); start_frame();
        repeat (N) send_force(40, -40);
        forces_done_in = 1;
        tick();
        forces_done_in = 0;
        repeat (4) tick();
        rst_in = 1;
        tick();
        rst_in = 0;
        check("t6 nodes zero", 256'(nodes_out), 256'(0));
        check("t6 overrun clear", 256'(overrun_out), 256'(1'b0));
        repeat (15) tick();
        fill(5, -3, 0, 0); start_frame();
        finish(0, 0, 0, lat);
        check("t6 p0y", 256'(nodes_out[1][0]), 256'(8'hFD));
        tick();
        repeat (20) rand_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
